c1541_stepper: RTL and testbench

C1541_STEPPER -- requirements
Module: c1541_stepper

---
 rtl/c1541_stepper.sv | 96 +++++++++
 tb/tb_c1541_stepper.sv | 393 +++++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/c1541_stepper.sv
// Head stepper tracker for a 1541 drive: follows VIA stepper phases, publishes the half-track
// once the head has settled, and raises save requests when a modified buffer must be written back.
module c1541_stepper #(
    parameter logic [15:0] SETTLE  = 16'd2000,
    parameter logic [7:0]  MAX_HT  = 8'd83,
    parameter logic [7:0]  HOME_HT = 8'd36
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       ce,
    input  logic       mtr,
    input  logic [1:0] step,
    input  logic       wr_byte,
    input  logic       busy,
    output logic [7:0] ht,
    output logic [7:0] track,
    output logic       save_track,
    output logic       dirty
);

    logic [1:0]  prev_step_q, prev_step_d;
    logic [15:0] settle_q, settle_d;
    logic        pending_q, pending_d;
    logic        mtr_q;
    logic        defer_q, defer_d;
    logic [7:0]  ht_d, track_d;
    logic        save_d, dirty_d;

    logic [1:0]  step_inc, step_dec;
    logic        move_up, move_dn, moving;
    logic        expire, publish, mtr_fall, flush, toggle;

    always_comb begin
        step_inc = prev_step_q + 2'd1;
        step_dec = prev_step_q - 2'd1;
        move_up  = ce & mtr & (step == step_inc) & (ht != MAX_HT);
        move_dn  = ce & mtr & (step == step_dec) & (ht != 8'd0);
        moving   = move_up | move_dn;

        ht_d = ht;
        if (move_up) begin
            ht_d = ht + 8'd1;
        end else if (move_dn) begin
            ht_d = ht - 8'd1;
        end

        prev_step_d = ce ? step : prev_step_q;

        settle_d = settle_q;
        if (moving) begin
            settle_d = SETTLE;
        end else if (ce && settle_q != 16'd0) begin
            settle_d = settle_q - 16'd1;
        end

        // Expiry with the head back where it was publishes nothing and saves nothing.
        expire  = pending_q & (settle_q == 16'd0) & ~busy & ~moving;
        publish = expire & (ht != track);

        mtr_fall = mtr_q & ~mtr;
        flush    = ((mtr_fall & dirty) | defer_q) & ~busy;
        // Flush and publish share one toggle so a coincident pair yields a single request.
        toggle   = flush | (publish & dirty);

        defer_d   = toggle ? 1'b0 : (defer_q | (mtr_fall & dirty));
        pending_d = moving ? 1'b1 : (expire ? 1'b0 : pending_q);
        track_d   = publish ? ht : track;
        save_d    = save_track ^ toggle;
        dirty_d   = wr_byte ? 1'b1 : (toggle ? 1'b0 : dirty);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            ht          <= HOME_HT;
            track       <= HOME_HT;
            save_track  <= 1'b0;
            dirty       <= 1'b0;
            settle_q    <= 16'd0;
            pending_q   <= 1'b0;
            prev_step_q <= step;
            defer_q     <= 1'b0;
            mtr_q       <= mtr;
        end else begin
            ht          <= ht_d;
            track       <= track_d;
            save_track  <= save_d;
            dirty       <= dirty_d;
            settle_q    <= settle_d;
            pending_q   <= pending_d;
            prev_step_q <= prev_step_d;
            defer_q     <= defer_d;
            mtr_q       <= mtr;
        end
    end

endmodule

// File: tb/tb_c1541_stepper.sv
// Scenario bench for c1541_stepper: expected output tuples are queued as stimulus is driven
// and popped at each observation point.
module tb_c1541_stepper;

    localparam logic [15:0] SETTLE = 16'd8;

    logic       clk = 1'b0;
    logic       reset = 1'b1;
    logic       ce = 1'b0;
    logic       mtr = 1'b0;
    logic [1:0] step = 2'd0;
    logic       wr_byte = 1'b0;
    logic       busy = 1'b0;
    logic [7:0] ht, track;
    logic       save_track, dirty;

    typedef struct {
        string       name;
        logic [17:0] v;  // {ht, track, save_track, dirty}
    } exp_t;

    exp_t sbq[$];
    exp_t e;
    int   checks = 0;
    int   failures = 0;

    c1541_stepper #(
        .SETTLE (SETTLE),
        .MAX_HT (8'd83),
        .HOME_HT(8'd36)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .ce        (ce),
        .mtr       (mtr),
        .step      (step),
        .wr_byte   (wr_byte),
        .busy      (busy),
        .ht        (ht),
        .track     (track),
        .save_track(save_track),
        .dirty     (dirty)
    );

    always #5 clk = ~clk;

    function automatic exp_t mk(input string n, input logic [7:0] h, input logic [7:0] t,
                                input logic s, input logic d);
        exp_t r;
        r.name = n;
        r.v    = {h, t, s, d};
        return r;
    endfunction

    task automatic do_reset(input logic [1:0] s);
        @(negedge clk);
        reset = 1'b1; step = s; ce = 1'b0; wr_byte = 1'b0; busy = 1'b0; mtr = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic ce_tick(input logic [1:0] s);
        @(negedge clk);
        step = s;
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        @(negedge clk);
    endtask

    task automatic wr_pulse();
        @(negedge clk);
        wr_byte = 1'b1;
        @(negedge clk);
        wr_byte = 1'b0;
    endtask

    task automatic test_reset();
        do_reset(2'd2);
        sbq.push_back(mk("reset_state", 8'd36, 8'd36, 1'b0, 1'b0));
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
        // prev_step was loaded with 2 during reset, so 3 is an inward step
        ce_tick(2'd3);
        sbq.push_back(mk("reset_prev_step", 8'd37, 8'd36, 1'b0, 1'b0));
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
        mtr = 1'b0;
        ce_tick(2'd0);
        mtr = 1'b1;
        ce_tick(2'd1);
        sbq.push_back(mk("motor_off_tracks_phase", 8'd38, 8'd36, 1'b0, 1'b0));
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
    endtask

    task automatic test_step_in();
        do_reset(2'd0);
        ce_tick(2'd0); ce_tick(2'd1); ce_tick(2'd2); ce_tick(2'd3);
        sbq.push_back(mk("step_in_ht", 8'd39, 8'd36, 1'b0, 1'b0));
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
        repeat (SETTLE - 1) ce_tick(2'd3);
        sbq.push_back(mk("settle_not_early", 8'd39, 8'd36, 1'b0, 1'b0));
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
        ce_tick(2'd3);
        sbq.push_back(mk("settle_publish", 8'd39, 8'd39, 1'b0, 1'b0));
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
        ce_tick(2'd1);
        sbq.push_back(mk("half_turn_no_move", 8'd39, 8'd39, 1'b0, 1'b0));
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
    endtask

    task automatic test_clamp_low();
        logic [1:0] s;
        do_reset(2'd0);
        s = 2'd0;
        for (int i = 0; i < 40; i++) begin
            s = s - 2'd1;
            ce_tick(s);
        end
        sbq.push_back(mk("clamp_low_ht", 8'd0, 8'd36, 1'b0, 1'b0));
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
        // four clamped ticks already counted down; four more expire the settle time
        repeat (4) ce_tick(s);
        sbq.push_back(mk("clamp_no_reload", 8'd0, 8'd0, 1'b0, 1'b0));
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
        for (int i = 0; i < 4; i++) begin
            s = s - 2'd1;
            ce_tick(s);
        end
        repeat (10) ce_tick(s);
        sbq.push_back(mk("clamp_low_idle", 8'd0, 8'd0, 1'b0, 1'b0));
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
    endtask

    task automatic test_clamp_high();
        logic [1:0] s;
        do_reset(2'd0);
        s = 2'd0;
        for (int i = 0; i < 52; i++) begin
            s = s + 2'd1;
            ce_tick(s);
        end
        sbq.push_back(mk("clamp_high_ht", 8'd83, 8'd36, 1'b0, 1'b0));
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
        repeat (SETTLE) ce_tick(s);
        sbq.push_back(mk("clamp_high_publish", 8'd83, 8'd83, 1'b0, 1'b0));
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
    endtask

    task automatic test_dirty_save();
        do_reset(2'd0);
        wr_pulse();
        sbq.push_back(mk("wr_sets_dirty", 8'd36, 8'd36, 1'b0, 1'b1));
        @(negedge clk);
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
        ce_tick(2'd1);
        repeat (SETTLE - 1) ce_tick(2'd1);
        @(negedge clk);
        ce = 1'b1;
        sbq.push_back(mk("save_not_early", 8'd37, 8'd36, 1'b0, 1'b1));
        sbq.push_back(mk("save_with_track", 8'd37, 8'd37, 1'b1, 1'b0));
        @(negedge clk);
        ce = 1'b0;
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
        @(negedge clk);
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
    endtask

    task automatic test_same_pos();
        do_reset(2'd0);
        wr_pulse();
        ce_tick(2'd1);
        ce_tick(2'd0);
        repeat (SETTLE + 2) ce_tick(2'd0);
        sbq.push_back(mk("same_pos_no_save", 8'd36, 8'd36, 1'b0, 1'b1));
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
    endtask

    task automatic test_busy_hold();
        logic [7:0] seen;
        do_reset(2'd0);
        busy = 1'b1;
        ce_tick(2'd1);
        repeat (SETTLE) ce_tick(2'd1);
        sbq.push_back(mk("busy_holds_track", 8'd37, 8'd36, 1'b0, 1'b0));
        seen = 8'd36;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (track !== 8'd36) seen = track;
        end
        busy = 1'b0;
        e = sbq.pop_front(); checks++;
        if ({ht, seen, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, seen, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
        sbq.push_back(mk("busy_release", 8'd37, 8'd37, 1'b0, 1'b0));
        @(negedge clk);
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
    endtask

    task automatic test_back_to_back();
        do_reset(2'd0);
        wr_pulse();
        ce_tick(2'd1);
        repeat (SETTLE - 1) ce_tick(2'd1);
        @(negedge clk);
        ce = 1'b1;
        @(negedge clk);
        ce = 1'b0;
        wr_byte = 1'b1;
        sbq.push_back(mk("wr_during_save", 8'd37, 8'd37, 1'b1, 1'b1));
        @(negedge clk);
        wr_byte = 1'b0;
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
        ce_tick(2'd2);
        repeat (SETTLE) ce_tick(2'd2);
        sbq.push_back(mk("second_save", 8'd38, 8'd38, 1'b0, 1'b0));
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
    endtask

    task automatic test_motor_flush();
        do_reset(2'd0);
        wr_pulse();
        @(negedge clk);
        mtr = 1'b0;
        sbq.push_back(mk("motor_off_flush", 8'd36, 8'd36, 1'b1, 1'b0));
        @(negedge clk);
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
        mtr = 1'b1;
        wr_byte = 1'b1;
        @(negedge clk);
        wr_byte = 1'b0;
        busy = 1'b1;
        @(negedge clk);
        mtr = 1'b0;
        @(negedge clk);
        mtr = 1'b1;
        sbq.push_back(mk("flush_deferred", 8'd36, 8'd36, 1'b1, 1'b1));
        repeat (5) @(negedge clk);
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
        busy = 1'b0;
        sbq.push_back(mk("flush_taken", 8'd36, 8'd36, 1'b0, 1'b0));
        @(negedge clk);
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
    endtask

    task automatic test_reset_discard();
        do_reset(2'd0);
        wr_pulse();
        ce_tick(2'd1);
        @(negedge clk);
        busy = 1'b1;
        mtr = 1'b0;
        @(negedge clk);
        @(negedge clk);
        do_reset(2'd0);
        repeat (SETTLE + 2) ce_tick(2'd0);
        sbq.push_back(mk("reset_discards", 8'd36, 8'd36, 1'b0, 1'b0));
        e = sbq.pop_front(); checks++;
        if ({ht, track, save_track, dirty} !== e.v) begin
            failures++;
            $display("FAIL %s: got ht=%0d track=%0d save=%b dirty=%b, want %0d %0d %b %b",
                     e.name, ht, track, save_track, dirty, e.v[17:10], e.v[9:2], e.v[1], e.v[0]);
        end
    endtask

    initial begin
        test_reset();
        test_step_in();
        test_clamp_low();
        test_clamp_high();
        test_dirty_save();
        test_same_pos();
        test_busy_hold();
        test_back_to_back();
        test_motor_flush();
        test_reset_discard();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
